// File: rtl/gate_input_debounce.sv
// gate_input_debounce: two-channel synchronizer + debouncer feeding the A/B
// inputs of the downstream two-input gate cells. Each channel produces a clean
// level plus one-cycle rise/fall pulses, all driven directly from flops.
//
// Optional build macro GATE_DEBOUNCE_GLITCH_CNT_EN adds per-channel 8-bit
// saturating counters of rejected bounces (A_glitch_cnt / B_glitch_cnt).

// Single debounce channel: 2-flop synchronizer followed by a counter FSM.
module gate_debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  output logic             lvl,
  output logic             rise,
  output logic             fall
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  // Terminal count: the Nth consecutive sample of a new level commits it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_WAIT_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_WAIT_LOW    = 2'd3
  } state_e;

  logic             s1;
  logic             s2;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; only s2 is visible to the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: a new level must persist DEBOUNCE_CYCLES samples to commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE_LOW;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE_LOW: begin
          if (s2) begin
            state <= ST_WAIT_HIGH;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s2) begin
            state <= ST_STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_STABLE_HIGH;
            cnt   <= '0;
            lvl   <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        ST_STABLE_HIGH: begin
          if (!s2) begin
            state <= ST_WAIT_LOW;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s2) begin
            state <= ST_STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_STABLE_LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  localparam int unsigned GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = GLITCH_W'(255);

  logic bounce_c;

  // A bounce is a pending change abandoned before reaching terminal count.
  assign bounce_c = ((state == ST_WAIT_HIGH) && !s2) ||
                    ((state == ST_WAIT_LOW)  &&  s2);

  // Saturating count of rejected bounces; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (bounce_c && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// Top level: two fully independent debounce channels.
module gate_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A_raw,
  input  logic       B_raw,
  output logic       A_out,
  output logic       B_out,
  output logic       A_rise,
  output logic       A_fall,
  output logic       B_rise,
  output logic       B_fall
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] A_glitch_cnt,
  output logic [7:0] B_glitch_cnt
`endif
);

  // Channel A conditioner.
  gate_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (A_raw),
    .lvl        (A_out),
    .rise       (A_rise),
    .fall       (A_fall)
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (A_glitch_cnt)
`endif
  );

  // Channel B conditioner.
  gate_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (B_raw),
    .lvl        (B_out),
    .rise       (B_rise),
    .fall       (B_fall)
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (B_glitch_cnt)
`endif
  );

endmodule

// File: tb/tb_gate_input_debounce.sv
// Bench for gate_input_debounce: vector table, directed multi-cycle corner
// sequences, and randomized inputs checked against a run-length reference model.
module tb_gate_input_debounce;

  localparam int DEB = 4;

  logic clk;
  logic rst_n;
  logic A_raw, B_raw;
  logic A_out, B_out, A_rise, A_fall, B_rise, B_fall;
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] A_glitch_cnt, B_glitch_cnt;
`endif

  gate_input_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A_raw  (A_raw),
    .B_raw  (B_raw),
    .A_out  (A_out),
    .B_out  (B_out),
    .A_rise (A_rise),
    .A_fall (A_fall),
    .B_rise (B_rise),
    .B_fall (B_fall)
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    ,
    .A_glitch_cnt (A_glitch_cnt),
    .B_glitch_cnt (B_glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is "level + length of the current run of
  // synchronized samples disagreeing with it"; the level flips when that run
  // reaches DEB. The synchronized sample is the raw input from two edges ago.
  bit       m_out  [2];
  int       m_run  [2];
  bit       m_rise [2];
  bit       m_fall [2];
  int       m_gl   [2];
  bit [1:0] m_dly  [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_out[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
      m_gl[c] = 0;  m_dly[c] = 2'b00;
    end
  endtask

  task automatic model_chan(input int c, input bit raw);
    bit seen;
    seen = m_dly[c][1];
    m_dly[c] = {m_dly[c][0], raw};
    m_rise[c] = 0;
    m_fall[c] = 0;
    if (seen != m_out[c]) begin
      m_run[c]++;
      if (m_run[c] == DEB) begin
        m_out[c] = seen;
        m_run[c] = 0;
        if (seen) m_rise[c] = 1; else m_fall[c] = 1;
      end
    end else begin
      if (m_run[c] != 0 && m_gl[c] < 255) m_gl[c]++;
      m_run[c] = 0;
    end
  endtask

  task automatic check_model();
    chk("model_a_out",  A_out,  m_out[0]);
    chk("model_b_out",  B_out,  m_out[1]);
    chk("model_a_rise", A_rise, m_rise[0]);
    chk("model_a_fall", A_fall, m_fall[0]);
    chk("model_b_rise", B_rise, m_rise[1]);
    chk("model_b_fall", B_fall, m_fall[1]);
    chk("a_rise_fall_excl", A_rise & A_fall, 0);
    chk("b_rise_fall_excl", B_rise & B_fall, 0);
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    chk("model_a_glitch", A_glitch_cnt, m_gl[0]);
    chk("model_b_glitch", B_glitch_cnt, m_gl[1]);
`endif
  endtask

  // One clock: drive raws, advance past the edge, update model, compare.
  task automatic step(input logic a, input logic b);
    A_raw = a;
    B_raw = b;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_chan(0, a);
      model_chan(1, b);
    end
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_out"},  A_out,  0);
    chk({tag, "_b_out"},  B_out,  0);
    chk({tag, "_a_rise"}, A_rise, 0);
    chk({tag, "_a_fall"}, A_fall, 0);
    chk({tag, "_b_rise"}, B_rise, 0);
    chk({tag, "_b_fall"}, B_fall, 0);
  endtask

  // Full reset with both raws low; returns one time unit after the release edge.
  task automatic apply_reset();
    A_raw = 0;
    B_raw = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit a_raw;
    bit b_raw;
    bit a_out;
    bit a_rise;
    bit a_fall;
    bit b_out;
  } vec_t;

  vec_t vec [16];

  initial begin
    // Clean rise then clean fall on A with B held low.
    for (int k = 0; k < 5; k++)   vec[k] = '{1, 0, 0, 0, 0, 0};
    vec[5] = '{1, 0, 1, 1, 0, 0};
    for (int k = 6; k < 10; k++)  vec[k] = '{1, 0, 1, 0, 0, 0};
    for (int k = 10; k < 15; k++) vec[k] = '{0, 0, 1, 0, 0, 0};
    vec[15] = '{0, 0, 0, 0, 1, 0};

    // Reset held with both raws high: everything stays 0.
    rst_n = 0;
    A_raw = 1;
    B_raw = 1;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      step(1, 1);
      chk("rst_exit_a_out",  A_out,  (k >= DEB + 1) ? 1 : 0);
      chk("rst_exit_b_out",  B_out,  (k >= DEB + 1) ? 1 : 0);
      chk("rst_exit_a_rise", A_rise, (k == DEB + 1) ? 1 : 0);
      chk("rst_exit_b_rise", B_rise, (k == DEB + 1) ? 1 : 0);
      chk("rst_exit_a_fall", A_fall, 0);
      chk("rst_exit_b_fall", B_fall, 0);
    end

    // Vector table: clean edges.
    apply_reset();
    repeat (3) step(0, 0);
    for (int k = 0; k < 16; k++) begin
      step(vec[k].a_raw, vec[k].b_raw);
      chk("vec_a_out",  A_out,  vec[k].a_out);
      chk("vec_a_rise", A_rise, vec[k].a_rise);
      chk("vec_a_fall", A_fall, vec[k].a_fall);
      chk("vec_b_out",  B_out,  vec[k].b_out);
    end

    // Bounce rejection: four 3-cycle pulses never commit.
    apply_reset();
    repeat (3) step(0, 0);
    for (int p = 0; p < 4; p++) begin
      repeat (3) begin
        step(1, 0);
        chk("bounce_a_out",  A_out,  0);
        chk("bounce_a_rise", A_rise, 0);
      end
      repeat (4) begin
        step(0, 0);
        chk("bounce_a_out",  A_out,  0);
        chk("bounce_a_fall", A_fall, 0);
      end
    end
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_a_glitch_cnt", A_glitch_cnt, 4);
`endif

    // Simultaneous rise; B bounces low for one cycle at capture index 2.
    apply_reset();
    repeat (3) step(0, 0);
    for (int k = 0; k < 12; k++) begin
      step(1, (k == 2) ? 0 : 1);
      chk("sim_a_out",  A_out,  (k >= 5) ? 1 : 0);
      chk("sim_a_rise", A_rise, (k == 5) ? 1 : 0);
      chk("sim_b_out",  B_out,  (k >= 8) ? 1 : 0);
      chk("sim_b_rise", B_rise, (k == 8) ? 1 : 0);
    end

    // Reset in the middle of an A rise while B_out is high.
    apply_reset();
    repeat (6) step(0, 1);
    chk("mid_pre_b_out", B_out, 1);
    repeat (4) step(1, 1);
    chk("mid_pre_a_out", A_out, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all_zero("mid_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("mid_held");
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      step(1, 1);
      chk("mid_exit_a_out",  A_out,  (k >= DEB + 1) ? 1 : 0);
      chk("mid_exit_a_rise", A_rise, (k == DEB + 1) ? 1 : 0);
      chk("mid_exit_a_fall", A_fall, 0);
    end

    // Randomized toggling against the reference model.
    apply_reset();
    begin
      logic a, b;
      a = 0;
      b = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(3) == 0) a = ~a;
        if ($urandom_range(4) == 0) b = ~b;
        step(a, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
